// File: rtl/fetch_dec_rcv_pkg.sv
// Shared constants and types for the decode-side fetch receiver.
// A bundle holds four slots. Slot 0 occupies the top 16 bits of each 64-bit field.
package fetch_dec_rcv_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int INST_W    = 16;
   localparam int PC_W      = 16;
   localparam int BUS_W     = NUM_SLOTS * INST_W;
   localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

   typedef struct packed {
      logic [BUS_W-1:0]     pc;
      logic [BUS_W-1:0]     inst;
      logic [BUS_W-1:0]     recv_pc;
      logic [NUM_SLOTS-1:0] pred;
   } bundle_t;

   localparam int BUNDLE_W = $bits(bundle_t);

   // Returns the MSB index of slot i within a 64-bit field (slot i at [hi -: 16]).
   function automatic int slot_hi(input int i);
      return BUS_W - 1 - INST_W * i;
   endfunction
endpackage

// File: rtl/fetch_dec_rcv_fifo.sv
// bundle_fifo: generic W x DEPTH synchronous FIFO with push, pop, flush and occupancy.
// Ports: clk, rst (sync, active high), push_req/pop_req (requests; they are gated
// internally by full/empty), flush (clears pointers and occ, and wins over push and pop),
// wdata/rdata (rdata is the registered head at rd_ptr), occ, full, empty.
module bundle_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_req,
   input  logic            pop_req,
   input  logic            flush,
   input  logic [W-1:0]    wdata,
   output logic [W-1:0]    rdata,
   output logic [CNTW-1:0] occ,
   output logic            full,
   output logic            empty
);
   localparam int PTRW = $clog2(DEPTH);

   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] occ_q, occ_d;
   logic [W-1:0]    mem_q [DEPTH];
   logic [W-1:0]    mem_d [DEPTH];
   logic            push, pop;

   assign full  = (occ_q == CNTW'(DEPTH));
   assign empty = (occ_q == '0);
   assign occ   = occ_q;
   assign rdata = mem_q[rd_ptr_q];

   // A pop in the same cycle does not make room for a push while full.
   assign push = push_req & ~full  & ~flush;
   assign pop  = pop_req  & ~empty & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         occ_d = occ_q + CNTW'(push) - CNTW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // The storage is not reset. Consumers mask it with !empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/fetch_dec_rcv.sv
// fetch_dec_rcv: decode-side receiver for the 4-wide fetch bundle.
// It buffers bundles in a DEPTH-entry FIFO and presents the oldest one to decode.
// Ports: clk, rst (sync, active high); fet_vld/fet_rdy plus pc/inst/recv_pc/pred inputs
// from fetch; flush; dec_rdy/dec_vld plus dec_* head fields and dec_slot_vld to decode;
// occ (buffered bundle count).
// fet_rdy depends only on registered occupancy, so there is no combinational path
// from dec_rdy.
module fetch_dec_rcv
   import fetch_dec_rcv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fet_vld,
   input  logic [BUS_W-1:0]     pc_to_dec,
   input  logic [BUS_W-1:0]     inst_to_dec,
   input  logic [BUS_W-1:0]     recv_pc_to_dec,
   input  logic [NUM_SLOTS-1:0] pred_result_to_dec,
   input  logic                 flush,
   input  logic                 dec_rdy,
   output logic                 fet_rdy,
   output logic                 dec_vld,
   output logic [BUS_W-1:0]     dec_pc,
   output logic [BUS_W-1:0]     dec_inst,
   output logic [BUS_W-1:0]     dec_recv_pc,
   output logic [NUM_SLOTS-1:0] dec_pred,
   output logic [NUM_SLOTS-1:0] dec_slot_vld,
   output logic [CNTW-1:0]      occ
);
   bundle_t                in_b, head_b;
   logic                   full, empty;
   logic [NUM_SLOTS-1:0]   slot_live;

   always_comb begin
      in_b         = '0;
      in_b.pc      = pc_to_dec;
      in_b.inst    = inst_to_dec;
      in_b.recv_pc = recv_pc_to_dec;
      in_b.pred    = pred_result_to_dec;
   end

   bundle_fifo #(
      .W     (BUNDLE_W),
      .DEPTH (DEPTH),
      .CNTW  (CNTW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_req (fet_vld),
      .pop_req  (dec_rdy),
      .flush    (flush),
      .wdata    (in_b),
      .rdata    (head_b),
      .occ      (occ),
      .full     (full),
      .empty    (empty)
   );

   assign fet_rdy = ~full;
   assign dec_vld = ~empty;

   // Slot 0 lives in the top bits of the bus but maps to bit 3 of the valid vector.
   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      localparam int HI = slot_hi(i);
      assign slot_live[NUM_SLOTS-1-i] = (head_b.inst[HI -: INST_W] != NOP_INST);
   end

   // Storage is not reset, so every field is masked while the head is invalid.
   always_comb begin
      dec_pc       = '0;
      dec_inst     = '0;
      dec_recv_pc  = '0;
      dec_pred     = '0;
      dec_slot_vld = '0;
      if (dec_vld) begin
         dec_pc       = head_b.pc;
         dec_inst     = head_b.inst;
         dec_recv_pc  = head_b.recv_pc;
         dec_pred     = head_b.pred;
         dec_slot_vld = slot_live;
      end
   end
endmodule

// File: tb/tb_fetch_dec_rcv.sv
// Scoreboard bench for fetch_dec_rcv: stimulus queues expected bundles on acceptance,
// and a negedge monitor compares every head that decode takes.
module tb_fetch_dec_rcv;
   import fetch_dec_rcv_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 rst, fet_vld, flush, dec_rdy;
   logic [BUS_W-1:0]     pc_to_dec, inst_to_dec, recv_pc_to_dec;
   logic [NUM_SLOTS-1:0] pred_result_to_dec;
   logic                 fet_rdy, dec_vld;
   logic [BUS_W-1:0]     dec_pc, dec_inst, dec_recv_pc;
   logic [NUM_SLOTS-1:0] dec_pred, dec_slot_vld;
   logic [CNTW-1:0]      occ;

   int      n_pass = 0;
   int      n_total = 0;
   int      n_pop = 0;
   bit      mon_en = 1'b0;
   bundle_t exp_q[$];

   always #5 clk = ~clk;

   fetch_dec_rcv #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .fet_vld(fet_vld), .pc_to_dec(pc_to_dec),
      .inst_to_dec(inst_to_dec), .recv_pc_to_dec(recv_pc_to_dec),
      .pred_result_to_dec(pred_result_to_dec), .flush(flush), .dec_rdy(dec_rdy),
      .fet_rdy(fet_rdy), .dec_vld(dec_vld), .dec_pc(dec_pc), .dec_inst(dec_inst),
      .dec_recv_pc(dec_recv_pc), .dec_pred(dec_pred), .dec_slot_vld(dec_slot_vld),
      .occ(occ)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Expected slot-valid bits straight from the definition: a nonzero instruction
   // marks the slot, and slot 0 maps to bit 3.
   function automatic logic [3:0] exp_slots(input logic [63:0] inst);
      logic [3:0] r;
      r[3] = inst[63:48] != 16'h0;
      r[2] = inst[47:32] != 16'h0;
      r[1] = inst[31:16] != 16'h0;
      r[0] = inst[15:0]  != 16'h0;
      return r;
   endfunction

   function automatic bundle_t mk(input logic [15:0] base, input logic [63:0] inst,
                                  input logic [3:0] pred);
      bundle_t b;
      b.pc      = {base, base + 16'd1, base + 16'd2, base + 16'd3};
      b.inst    = inst;
      b.recv_pc = {base + 16'h100, base + 16'h104, base + 16'h108, base + 16'h10C};
      b.pred    = pred;
      return b;
   endfunction

   task automatic drive(input bundle_t b);
      pc_to_dec          = b.pc;
      inst_to_dec        = b.inst;
      recv_pc_to_dec     = b.recv_pc;
      pred_result_to_dec = b.pred;
   endtask

   // Presents b until it is accepted (bounded), then records it as expected.
   task automatic send(input bundle_t b);
      int k = 0;
      drive(b);
      fet_vld = 1'b1;
      @(negedge clk);
      while (!fet_rdy && k < 50) begin
         k++;
         @(negedge clk);
      end
      if (!fet_rdy) begin
         chk("send_timeout", 64'd0, 64'd1);
      end else begin
         @(posedge clk);
         exp_q.push_back(b);
         #1;
      end
      fet_vld = 1'b0;
   endtask

   task automatic wait_empty();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      #1;
   endtask

   // Monitor: dec_vld must track the model, idle outputs must be zero, and every
   // head that decode accepts must match the oldest expected bundle.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("vld_vs_model", 64'(dec_vld), 64'(exp_q.size() != 0));
         if (!dec_vld) begin
            chk("idle_zero", 64'((|dec_pc) | (|dec_inst) | (|dec_recv_pc) |
                                 (|dec_pred) | (|dec_slot_vld)), 64'd0);
         end else if (dec_rdy && !flush && !rst && exp_q.size() != 0) begin
            bundle_t e;
            e = exp_q.pop_front();
            n_pop++;
            chk("head_pc",   dec_pc,      e.pc);
            chk("head_inst", dec_inst,    e.inst);
            chk("head_rpc",  dec_recv_pc, e.recv_pc);
            chk("head_pred", 64'(dec_pred), 64'(e.pred));
            chk("head_slot", 64'(dec_slot_vld), 64'(exp_slots(e.inst)));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bundle_t a, b, c, x, y;
      int      pops0;
      rst = 1'b1; fet_vld = 1'b0; flush = 1'b0; dec_rdy = 1'b0;
      pc_to_dec = '0; inst_to_dec = '0; recv_pc_to_dec = '0; pred_result_to_dec = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_occ", 64'(occ), 64'd0);
      chk("rst_fet_rdy", 64'(fet_rdy), 64'd1);
      chk("rst_dec_vld", 64'(dec_vld), 64'd0);
      mon_en = 1'b1;

      // Single bundle: presented one cycle after the push, then gone after decode takes it.
      @(posedge clk); #1;
      dec_rdy = 1'b1;
      a.pc = 64'h0010_0011_0012_0013; a.inst = 64'h1234_0000_5678_9ABC;
      a.recv_pc = 64'h0020_0024_0028_002C; a.pred = 4'b0100;
      send(a);
      @(negedge clk);
      chk("single_vld",  64'(dec_vld), 64'd1);
      chk("single_slot", 64'(dec_slot_vld), 64'hB);
      chk("single_pc",   dec_pc, 64'h0010_0011_0012_0013);
      @(negedge clk);
      chk("single_gone", 64'(dec_vld), 64'd0);

      // Fill and backpressure: A and B accepted, C held until a pop from full.
      @(posedge clk); #1;
      dec_rdy = 1'b0;
      a = mk(16'h1000, 64'h1111_2222_3333_4444, 4'b1000);
      b = mk(16'h2000, 64'h0000_5555_0000_6666, 4'b0001);
      c = mk(16'h3000, 64'h7777_0000_0000_0000, 4'b1111);
      send(a);
      send(b);
      drive(c); fet_vld = 1'b1;
      @(negedge clk);
      chk("fill_occ", 64'(occ), 64'd2);
      chk("fill_fet_rdy", 64'(fet_rdy), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fill_held", 64'(fet_rdy), 64'd0);
      @(posedge clk); #1;
      dec_rdy = 1'b1;
      send(c);
      wait_empty();

      // Simultaneous push and pop at occ=1.
      dec_rdy = 1'b0;
      x = mk(16'h4000, 64'h0001_0002_0003_0004, 4'b0010);
      y = mk(16'h5000, 64'h0000_0000_0000_0009, 4'b0110);
      send(x);
      @(negedge clk);
      chk("pp_occ_before", 64'(occ), 64'd1);
      @(posedge clk); #1;
      dec_rdy = 1'b1;
      send(y);
      @(negedge clk);
      chk("pp_occ_after", 64'(occ), 64'd1);
      chk("pp_head", dec_pc, y.pc);
      wait_empty();

      // Flush priority: flush with fet_vld and dec_rdy discards everything.
      dec_rdy = 1'b0;
      send(mk(16'h6000, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0011));
      send(mk(16'h6100, 64'hEEEE_0000_FFFF_0000, 4'b1100));
      drive(mk(16'h6200, 64'h0BAD_0BAD_0BAD_0BAD, 4'b1010));
      fet_vld = 1'b1; flush = 1'b1; dec_rdy = 1'b1;
      @(posedge clk);
      exp_q.delete();
      #1 flush = 1'b0; fet_vld = 1'b0;
      @(negedge clk);
      chk("flush_occ", 64'(occ), 64'd0);
      chk("flush_dec_vld", 64'(dec_vld), 64'd0);
      chk("flush_fet_rdy", 64'(fet_rdy), 64'd1);
      @(posedge clk); #1;
      send(mk(16'h6300, 64'h1357_2468_0000_1111, 4'b0101));
      wait_empty();

      // Wrap-around: 10 bundles while decode toggles ready every cycle.
      pops0 = n_pop;
      fork
         begin
            for (int i = 0; i < 10; i++)
               send(mk(16'h8000 + 16'(4 * i), {16'hC000 + 16'(i), 16'h0, 16'(i + 1), 16'hF00D},
                       4'(i)));
         end
         begin
            for (int t = 0; t < 40; t++) begin
               dec_rdy = ~dec_rdy;
               @(posedge clk); #1;
            end
         end
      join
      dec_rdy = 1'b1;
      wait_empty();
      chk("wrap_count", 64'(n_pop - pops0), 64'd10);

      // Mid-stream reset with two bundles buffered.
      dec_rdy = 1'b0;
      send(mk(16'h9000, 64'h9999_8888_7777_6666, 4'b1001));
      send(mk(16'h9100, 64'h5555_4444_3333_2222, 4'b0110));
      rst = 1'b1;
      @(posedge clk);
      exp_q.delete();
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mrst_occ", 64'(occ), 64'd0);
      chk("mrst_fet_rdy", 64'(fet_rdy), 64'd1);
      chk("mrst_dec_vld", 64'(dec_vld), 64'd0);
      chk("mrst_pc", dec_pc, 64'd0);
      @(posedge clk); #1;
      dec_rdy = 1'b1;
      send(mk(16'hA000, 64'h0000_0000_0000_0001, 4'b0000));
      wait_empty();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fetch_dec_rcv.md
# fetch_dec_rcv

Decode-side receiver for the 4-wide fetch bundle. It captures each bundle of PCs, instructions, recovery PCs and prediction bits into a small FIFO. It presents the oldest bundle to decode with per-slot valid bits and a valid/ready handshake, and it drops all buffered state on a pipeline flush. It sits between the fetch-stage output packer and the decode stage, so fetch never has to hold a bundle when decode stalls for a cycle.

## Interface
Parameters:
- DEPTH, 2: bundle entries in the FIFO; must be a power of two, at least 2.
- CNTW, $clog2(DEPTH)+1: width of the occupancy counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fet_vld  in  1  a fetch bundle is present this cycle.
- pc_to_dec  in  64  four PCs; slot 0 is in [63:48], slot 3 in [15:0].
- inst_to_dec  in  64  four instructions, same slot order; 16'h0000 is a squashed slot (nop).
- recv_pc_to_dec  in  64  per-slot recovery PC, same slot order.
- pred_result_to_dec  in  4  per-slot predicted-taken bit; bit 3 is slot 0.
- flush  in  1  mispredict or exception redirect; empties the buffer.
- dec_rdy  in  1  decode accepts the presented bundle.
- fet_rdy  out  1  receiver can accept a bundle; equals !full; registered-state only, with no combinational path from dec_rdy.
- dec_vld  out  1  head bundle is valid.
- dec_pc, dec_inst, dec_recv_pc  out  64 each  head bundle fields, same slot order as the inputs.
- dec_pred  out  4  head prediction bits.
- dec_slot_vld  out  4  per slot: (instruction != 0) & dec_vld.
- occ  out  CNTW  current number of buffered bundles.

## Operation
- Push: fet_vld & fet_rdy & !flush. The bundle is written at wr_ptr, and wr_ptr increments mod DEPTH.
- Pop: dec_vld & dec_rdy & !flush. rd_ptr increments mod DEPTH.
- Push and pop in the same cycle leave occ unchanged. Both pointers advance.
- fet_vld while full: the bundle is not taken, and fetch must hold it. Same-cycle pops do not make room for it.
- flush has priority over push and pop in the same cycle. Pointers and occ clear to 0, and the incoming bundle is discarded.
- Head outputs are read from storage at rd_ptr (a registered array), so they are valid in the cycle dec_vld is high.
- When dec_vld=0, all data outputs are driven to 0 and dec_slot_vld=0.
- dec_slot_vld is derived from the stored instruction: a zeroed slot is never marked valid, even if its PC is nonzero.
- Prediction bits and recovery PCs pass through unaltered. The receiver performs no branch interpretation.
- Pointer and occupancy arithmetic is unsigned.
  - occ counts 0..DEPTH.
  - full = (occ == DEPTH); empty = (occ == 0).
  - Pointers are log2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset takes effect on the first rising edge with rst=1. Afterwards occ=0, both pointers are 0, dec_vld=0, all data outputs are 0, and fet_rdy=1.
- Storage contents need not be reset; the output zeroing masks them.
- Latency: a bundle pushed at edge N is presented with dec_vld=1 in the cycle after edge N. There is no same-cycle bypass.
- Throughput: one bundle per cycle in steady state while dec_rdy=1 (occ stays at 1).
- fet_rdy drops in the cycle after the edge where occ reaches DEPTH. It rises in the cycle after the edge of a pop from full.
- flush at edge N: dec_vld=0 and fet_rdy=1 in the following cycle. A bundle presented in the flush cycle is lost.
- rst asserted mid-stream has the same effect as flush, plus a return to the reset values.

## Structure
- A shared package holds the bundle constants: NUM_SLOTS=4, INST_W=16, PC_W=16, NOP_INST=16'h0000, and the slot-to-bit-range mapping (slot i at [63-16i -: 16]).
- One natural sub-module: `bundle_fifo`, a generic width-by-DEPTH synchronous FIFO with push, pop, flush and occ. fetch_dec_rcv wraps it and adds the output masking and slot-valid logic.

## Test plan
- Single bundle:
  - Stimulus: after reset, fet_vld=1 for one cycle with pc_to_dec=64'h0010_0011_0012_0013, inst_to_dec=64'h1234_0000_5678_9ABC, pred=4'b0100, dec_rdy=1.
  - Response: in the next cycle dec_vld=1, the fields match the inputs, dec_slot_vld=4'b1011; one cycle later dec_vld=0.
- Fill and backpressure:
  - Stimulus: dec_rdy=0 with three consecutive bundles A, B, C (DEPTH=2).
  - Response: A and B accepted, occ=2, fet_rdy=0 while C is held. When dec_rdy=1, the output order is A, then B, then C.
- Simultaneous push and pop:
  - Stimulus: occ=1, fet_vld=1, dec_rdy=1.
  - Response: occ stays 1 and the next head is the new bundle.
- Flush priority:
  - Stimulus: occ=2, flush=1 together with fet_vld=1 and dec_rdy=1.
  - Response: the next cycle has occ=0, dec_vld=0, fet_rdy=1, and the flushed-cycle bundle never appears.
- Wrap-around:
  - Stimulus: 10 bundles with PC base incrementing by 4, dec_rdy toggling every cycle.
  - Response: all 10 emerge in order with no loss or duplication, across at least 4 pointer wraps.
- Reset mid-stream:
  - Stimulus: occ=2, rst=1 for one cycle.
  - Response: all outputs 0, fet_rdy=1, and no stale bundle appears afterwards.
